rv64i_mini_soc: RTL and testbench



---
 rtl/rv64_pkg.sv | 21 ++
 rtl/regs.sv | 22 ++
 rtl/riscv.sv | 39 +++
 rtl/rom.sv | 11 +
 rtl/rv64i_mini_soc.sv | 14 +
 tb/tb_rv64i_mini_soc.sv | 224 ++++++++++++++++++++++
 6 files changed

// File: rtl/rv64_pkg.sv
// rv64_pkg: shared RV64I opcode/funct constants, sizes and immediate generator
package rv64_pkg;
  localparam int XLEN = 64;
  localparam int ROM_DEPTH = 4096;
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] i);
    return i[6:0] == OP_IMM ? {{(XLEN-12){i[31]}}, i[31:20]} :
           i[6:0] == LUI    ? {{(XLEN-32){i[31]}}, i[31:12], 12'b0} :
           i[6:0] == BRANCH ? {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
           i[6:0] == JAL    ? {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0} : '0;
  endfunction
endpackage

// File: rtl/regs.sv
// regs: 32-entry register file, two combinational reads, one clocked write, x0 hardwired to 0
module regs #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  input  logic         we,
  input  logic [4:0]   wa,
  input  logic [W-1:0] wd,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2
);
  logic [W-1:0] regs [0:31];
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  end
endmodule

// File: rtl/riscv.sv
// riscv: single-cycle RV64I subset core (ADD/SUB/ADDI/LUI/BEQ/BNE/JAL), all else NOP
module riscv import rv64_pkg::*; #(
  parameter int W = XLEN,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr,
  output logic [AW-1:0] addr
);
  logic [W-1:0] pc, next_pc, rd1, rd2, imm, wd;
  logic is_add, is_sub, is_addi, is_lui, is_br, is_jal, we, taken;
  assign is_add  = instr[6:0] == OP && instr[14:12] == F3_ADD && instr[31:25] == F7_ADD;
  assign is_sub  = instr[6:0] == OP && instr[14:12] == F3_ADD && instr[31:25] == F7_SUB;
  assign is_addi = instr[6:0] == OP_IMM && instr[14:12] == F3_ADD;
  assign is_lui  = instr[6:0] == LUI;
  assign is_br   = instr[6:0] == BRANCH && (instr[14:12] == F3_BEQ || instr[14:12] == F3_BNE);
  assign is_jal  = instr[6:0] == JAL;
  assign imm = imm_gen(instr);
  assign we = is_add | is_sub | is_addi | is_lui | is_jal;
  assign wd = is_add  ? rd1 + rd2 :
              is_sub  ? rd1 - rd2 :
              is_addi ? rd1 + imm :
              is_lui  ? imm : pc + 4;
  // funct3[0] distinguishes BNE from BEQ, so it inverts the equality test
  assign taken = is_jal | (is_br & ((rd1 == rd2) ^ instr[12]));
  assign next_pc = (taken ? pc + imm : pc + 4) & ~W'(3);
  assign addr = pc[AW+1:2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else pc <= next_pc;
  end
  regs #(.W(W)) regs_inst (
    .clk(clk), .rst(rst),
    .ra1(instr[19:15]), .ra2(instr[24:20]),
    .we(we), .wa(instr[11:7]), .wd(wd),
    .rd1(rd1), .rd2(rd2)
  );
endmodule

// File: rtl/rom.sv
// rom: combinational instruction storage, contents loaded externally
module rom #(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   instr
);
  logic [31:0] rom_mem [0:DEPTH-1];
  assign instr = rom_mem[addr];
endmodule

// File: rtl/rv64i_mini_soc.sv
// rv64i_mini_soc: single-cycle RV64I core plus combinational instruction ROM
module rv64i_mini_soc #(
  parameter int ROM_DEPTH = rv64_pkg::ROM_DEPTH,
  parameter int XLEN = rv64_pkg::XLEN
) (
  input logic clk,
  input logic rst
);
  localparam int AW = $clog2(ROM_DEPTH);
  logic [AW-1:0] addr;
  logic [31:0] instr;
  rom #(.DEPTH(ROM_DEPTH), .AW(AW)) rom_inst (.addr(addr), .instr(instr));
  riscv #(.W(XLEN), .AW(AW)) riscv_inst (.clk(clk), .rst(rst), .instr(instr), .addr(addr));
endmodule

// File: tb/tb_rv64i_mini_soc.sv
// tb_rv64i_mini_soc: directed program vectors, reset corner cases and random programs vs an ISA model
module tb_rv64i_mini_soc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rv64i_mini_soc dut (.clk(clk), .rst(rst));
  int checks = 0;
  int errors = 0;
  logic [31:0] img [0:4095];
  logic [63:0] mx [0:31];
  logic [63:0] mpc;
  typedef struct packed {
    logic [63:0] name;
    logic [7:0][31:0] prog;
    logic [7:0] edges;
    logic [3:0][4:0] r;
    logic [3:0][63:0] v;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h13};
  endfunction
  function automatic logic [31:0] rtype(input int f7, input int rd, input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] lui(input int rd, input int imm20);
    return {imm20[19:0], rd[4:0], 7'h37};
  endfunction
  function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int o);
    return {o[12], o[10:5], rs2[4:0], rs1[4:0], f3[2:0], o[4:1], o[11], 7'h63};
  endfunction
  function automatic logic [31:0] jal(input int rd, input int o);
    return {o[20], o[10:1], o[11], o[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic load_img();
    for (int k = 0; k < 4096; k++) dut.rom_inst.rom_mem[k] = img[k];
  endtask
  task automatic clear_img();
    for (int k = 0; k < 4096; k++) img[k] = 32'h0;
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mx[k] = 64'h0;
    mpc = 64'h0;
  endtask
  task automatic model_step();
    logic [31:0] i;
    logic [63:0] a, b, res, nxt, ii, iu, ib, ij;
    logic wr;
    i = img[mpc[13:2]];
    a = mx[i[19:15]];
    b = mx[i[24:20]];
    ii = $signed(i[31:20]);
    iu = $signed({i[31:12], 12'h000});
    ib = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
    ij = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
    res = 64'h0;
    wr = 1'b0;
    nxt = mpc + 64'd4;
    if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'h00) begin res = a + b; wr = 1'b1; end
    else if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'h20) begin res = a - b; wr = 1'b1; end
    else if (i[6:0] == 7'h13 && i[14:12] == 3'd0) begin res = a + ii; wr = 1'b1; end
    else if (i[6:0] == 7'h37) begin res = iu; wr = 1'b1; end
    else if (i[6:0] == 7'h63 && i[14:13] == 2'd0) begin
      if ((a == b) == (i[12] == 1'b0)) nxt = mpc + ib;
    end
    else if (i[6:0] == 7'h6f) begin res = mpc + 64'd4; wr = 1'b1; nxt = mpc + ij; end
    if (wr && i[11:7] != 5'd0) mx[i[11:7]] = res;
    mpc = nxt;
  endtask

  function automatic logic [31:0] rand_instr();
    int rd, rs1, rs2, o;
    logic [31:0] w;
    rd = int'($urandom_range(0, 7));
    rs1 = int'($urandom_range(0, 7));
    rs2 = int'($urandom_range(0, 7));
    o = (int'($urandom_range(0, 10)) - 5) * 4;
    if (o == 0) o = 8;
    case ($urandom_range(0, 7))
      0: return addi(rd, rs1, int'($urandom));
      1: return rtype(0, rd, rs1, rs2);
      2: return rtype(32, rd, rs1, rs2);
      3: return lui(rd, int'($urandom));
      4: return br(0, rs1, rs2, o);
      5: return br(1, rs1, rs2, o);
      6: return jal(rd, o);
      default: begin
        w = $urandom;
        if (w[6:0] == 7'h63 || w[6:0] == 7'h6f) w[6:0] = 7'h0b;
        return w;
      end
    endcase
  endfunction

  initial begin
    vecs[0] = '0;
    vecs[0].name = "add";
    vecs[0].prog[0] = addi(27, 0, 5);
    vecs[0].prog[1] = addi(28, 0, 7);
    vecs[0].prog[2] = rtype(0, 29, 27, 28);
    vecs[0].edges = 3;
    vecs[0].r = {5'd0, 5'd29, 5'd28, 5'd27};
    vecs[0].v = {64'd0, 64'd12, 64'd7, 64'd5};
    vecs[1] = '0;
    vecs[1].name = "sub";
    vecs[1].prog[0] = addi(27, 0, 3);
    vecs[1].prog[1] = addi(28, 0, 10);
    vecs[1].prog[2] = rtype(32, 29, 27, 28);
    vecs[1].edges = 3;
    vecs[1].r = {5'd0, 5'd29, 5'd28, 5'd27};
    vecs[1].v = {64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd10, 64'd3};
    vecs[2] = '0;
    vecs[2].name = "x0";
    vecs[2].prog[0] = addi(0, 0, 9);
    vecs[2].prog[1] = rtype(0, 29, 0, 0);
    vecs[2].edges = 2;
    vecs[2].r = {5'd0, 5'd0, 5'd29, 5'd0};
    vecs[2].v = {64'd0, 64'd0, 64'd0, 64'd0};
    vecs[3] = '0;
    vecs[3].name = "loop";
    vecs[3].prog[0] = addi(28, 0, 3);
    vecs[3].prog[1] = addi(29, 29, 1);
    vecs[3].prog[2] = br(1, 29, 28, -4);
    vecs[3].prog[3] = addi(27, 0, 1);
    vecs[3].edges = 8;
    vecs[3].r = {5'd0, 5'd28, 5'd27, 5'd29};
    vecs[3].v = {64'd0, 64'd3, 64'd1, 64'd3};
    vecs[4] = '0;
    vecs[4].name = "luijal";
    vecs[4].prog[0] = lui(27, 'h80000);
    vecs[4].prog[1] = jal(28, 8);
    vecs[4].prog[2] = addi(29, 0, 1);
    vecs[4].prog[3] = addi(26, 0, 2);
    vecs[4].edges = 3;
    vecs[4].r = {5'd26, 5'd29, 5'd28, 5'd27};
    vecs[4].v = {64'd2, 64'd0, 64'd8, 64'hFFFF_FFFF_8000_0000};
    vecs[5] = '0;
    vecs[5].name = "beq";
    vecs[5].prog[0] = addi(27, 0, 4);
    vecs[5].prog[1] = br(0, 27, 0, 8);
    vecs[5].prog[2] = addi(28, 0, 1);
    vecs[5].prog[3] = br(0, 0, 0, 8);
    vecs[5].prog[4] = addi(29, 0, 1);
    vecs[5].prog[5] = addi(26, 0, 2);
    vecs[5].edges = 5;
    vecs[5].r = {5'd27, 5'd26, 5'd29, 5'd28};
    vecs[5].v = {64'd4, 64'd2, 64'd0, 64'd1};

    for (int n = 0; n < 6; n++) begin
      clear_img();
      for (int j = 0; j < 8; j++) img[j] = vecs[n].prog[j];
      load_img();
      reset_dut();
      if (n == 0)
        for (int k = 0; k < 32; k++)
          check($sformatf("reset x%0d", k), dut.riscv_inst.regs_inst.regs[k], 64'h0);
      run(int'(vecs[n].edges));
      for (int j = 0; j < 4; j++)
        check($sformatf("%s x%0d", vecs[n].name, vecs[n].r[j]),
              dut.riscv_inst.regs_inst.regs[vecs[n].r[j]], vecs[n].v[j]);
    end

    // asynchronous reset between edges, then restart from pc 0
    clear_img();
    img[0] = addi(27, 0, 5);
    img[1] = addi(28, 0, 7);
    img[2] = rtype(0, 29, 27, 28);
    load_img();
    reset_dut();
    run(2);
    check("midrun x28 before rst", dut.riscv_inst.regs_inst.regs[28], 64'd7);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 32; k++)
      check($sformatf("midrun clear x%0d", k), dut.riscv_inst.regs_inst.regs[k], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run(1);
    check("restart x27", dut.riscv_inst.regs_inst.regs[27], 64'd5);
    check("restart x28", dut.riscv_inst.regs_inst.regs[28], 64'd0);
    run(2);
    check("restart x29", dut.riscv_inst.regs_inst.regs[29], 64'd12);

    for (int t = 0; t < 6; t++) begin
      clear_img();
      for (int k = 0; k < 24; k++) img[k] = rand_instr();
      load_img();
      reset_dut();
      model_reset();
      for (int e = 0; e < 40; e++) begin
        run(1);
        model_step();
        for (int k = 0; k < 32; k++)
          check($sformatf("rnd%0d edge%0d x%0d", t, e, k), dut.riscv_inst.regs_inst.regs[k], mx[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
